// File: rtl/img_arb_pkg.sv
// Shared types and default widths for the image RAM arbiter.
package img_arb_pkg;

  localparam int unsigned DefAddrW       = 16;
  localparam int unsigned DefDataW       = 8;
  localparam int unsigned DefMaxDspBurst = 4;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    SWAP
  } swap_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DSP,
    SRC_FLT
  } src_t;

endpackage

// File: rtl/img_arb_swap_fsm.sv
// Front/back bank swap control: arms on filter frame completion and swaps on the
// next vsync falling edge, spending exactly one cycle in SWAP.
module img_arb_swap_fsm
  import img_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n,
  input  logic i_vsync,
  input  logic i_frame_done,
  output logic o_swap,
  output logic o_front_bank,
  output logic o_swap_ack
);

  swap_state_t r_state;
  swap_state_t w_state_nxt;
  logic        r_vsync;
  logic        r_front_bank;
  logic        w_vsync_fall;

  assign w_vsync_fall = r_vsync & ~i_vsync;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_vsync      <= 1'b1;
      r_front_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vsync <= i_vsync;
      if (r_state == SWAP) begin
        r_front_bank <= ~r_front_bank;
      end
    end
  end

  // A frame_done coinciding with a vsync edge in RUN only arms; the swap waits a frame.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (i_frame_done) w_state_nxt = PEND;
      PEND:    if (w_vsync_fall) w_state_nxt = SWAP;
      SWAP:    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    o_swap       = (r_state == SWAP);
    o_swap_ack   = (r_state == SWAP);
    o_front_bank = r_front_bank;
  end

endmodule

// File: rtl/img_mem_arbiter.sv
// Single-port double-banked image RAM arbiter: display reads the front bank with
// bounded priority, the filter owns the back bank, banks swap at vsync.
module img_mem_arbiter
  import img_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = DefAddrW,
  parameter int unsigned DATA_W        = DefDataW,
  parameter int unsigned MAX_DSP_BURST = DefMaxDspBurst
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              i_vsync,
  input  logic              i_de_window,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic              dsp_gnt,
  output logic              dsp_rvalid,
  output logic [DATA_W-1:0] dsp_rdata,
  input  logic              flt_req,
  input  logic              flt_we,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [DATA_W-1:0] flt_wdata,
  output logic              flt_gnt,
  output logic              flt_rvalid,
  output logic [DATA_W-1:0] flt_rdata,
  input  logic              flt_frame_done,
  output logic              flt_swap_ack,
  output logic              o_front_bank,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned RunW = $clog2(MAX_DSP_BURST + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_DSP_BURST);

  logic              w_swap;
  logic              w_front_bank;
  logic              w_dsp_wins;
  logic              w_dsp_gnt;
  logic              w_flt_gnt;
  logic [RunW-1:0]   r_dsp_run;
  logic [RunW-1:0]   w_dsp_run_nxt;
  src_t              w_src;
  src_t              r_tag0;
  src_t              r_tag1;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W:0]   r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  img_arb_swap_fsm u_swap_fsm (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .i_vsync      (i_vsync),
    .i_frame_done (flt_frame_done),
    .o_swap       (w_swap),
    .o_front_bank (w_front_bank),
    .o_swap_ack   (flt_swap_ack)
  );

  // Outside the window the filter wins conflicts; inside, only after a full display burst.
  assign w_dsp_wins = dsp_req & ~(flt_req & (~i_de_window | (r_dsp_run == RunMax)));
  assign w_dsp_gnt  = rst_n & ~w_swap & w_dsp_wins;
  assign w_flt_gnt  = rst_n & ~w_swap & flt_req & ~w_dsp_wins;

  always_comb begin
    w_dsp_run_nxt = r_dsp_run;
    if (!i_de_window || !flt_req || w_flt_gnt) begin
      w_dsp_run_nxt = '0;
    end else if (w_dsp_gnt) begin
      w_dsp_run_nxt = r_dsp_run + 1'b1;
    end
  end

  always_comb begin
    w_src = SRC_NONE;
    if (w_dsp_gnt) begin
      w_src = SRC_DSP;
    end else if (w_flt_gnt && !flt_we) begin
      w_src = SRC_FLT;
    end
  end

  // Bank bit is captured at grant time, so reads in flight survive a swap.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_dsp_run   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag0      <= SRC_NONE;
      r_tag1      <= SRC_NONE;
    end else begin
      r_dsp_run <= w_dsp_run_nxt;
      r_mem_en  <= w_dsp_gnt | w_flt_gnt;
      r_mem_we  <= w_flt_gnt & flt_we;
      if (w_dsp_gnt) begin
        r_mem_addr <= {w_front_bank, dsp_addr};
      end else if (w_flt_gnt) begin
        r_mem_addr  <= {~w_front_bank, flt_addr};
        r_mem_wdata <= flt_wdata;
      end
      r_tag0 <= w_src;
      r_tag1 <= r_tag0;
    end
  end

  assign dsp_gnt      = w_dsp_gnt;
  assign flt_gnt      = w_flt_gnt;
  assign o_front_bank = w_front_bank;
  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign dsp_rvalid   = (r_tag1 == SRC_DSP);
  assign flt_rvalid   = (r_tag1 == SRC_FLT);
  assign dsp_rdata    = mem_rdata;
  assign flt_rdata    = mem_rdata;

endmodule

// File: doc/img_mem_arbiter.md
# img_mem_arbiter

Arbitrates a single-port, double-banked image RAM between the HDMI display fetch path and the image filter engine, all in the `sys_clk` domain. The display fetch is the latency-critical reader and gets priority. The filter engine gets guaranteed slots and full read/write access to the back bank. At vertical sync the block swaps front and back banks once the filter reports a finished frame.

## Interface
- `ADDR_W`, 16: pixel address width per bank (225×225 image fits).
- `DATA_W`, 8: pixel width (grey level).
- `MAX_DSP_BURST`, 4: maximum consecutive display grants while the filter is waiting, in the active window.

- `clk_i` in 1: `sys_clk`. Single clock; every output and flop is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_vsync` in 1: active-low vertical sync from video timing.
- `i_de_window` in 1: high while the display image window is active.
- `dsp_req` in 1, `dsp_addr` in ADDR_W: display read request.
- `dsp_gnt` out 1, `dsp_rvalid` out 1, `dsp_rdata` out DATA_W: display grant and read return.
- `flt_req` in 1, `flt_we` in 1, `flt_addr` in ADDR_W, `flt_wdata` in DATA_W: filter request.
- `flt_gnt` out 1, `flt_rvalid` out 1, `flt_rdata` out DATA_W: filter grant and read return.
- `flt_frame_done` in 1: one-cycle pulse when the back bank is complete.
- `flt_swap_ack` out 1: one-cycle pulse when a swap has taken effect.
- `o_front_bank` out 1: bank currently shown.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out ADDR_W+1, `mem_wdata` out DATA_W, `mem_rdata` in DATA_W: RAM port. The MSB of `mem_addr` is the bank. The RAM has 1-cycle read latency.

## Operation
- The display always accesses the front bank: `mem_addr = {o_front_bank, dsp_addr}`. The filter always accesses the back bank: `{~o_front_bank, flt_addr}`.
- Requests are level-held until granted. At most one grant per cycle, and grants are combinational from the current-cycle requests. A grant completes the transfer; the requester may change the request on the next cycle.
- Arbitration while `i_de_window` = 1:
  - Display wins unless `dsp_run == MAX_DSP_BURST` and `flt_req` = 1; in that case the filter wins.
  - `dsp_run` counts display grants issued while `flt_req` is pending. It clears on any filter grant, and whenever `flt_req` = 0.
- Arbitration while `i_de_window` = 0: the filter wins on conflict and `dsp_run` is held at 0.
- A lone requester is granted immediately, except in the SWAP cycle.
- Swap FSM (`swap_state_t`):
  - RUN: `flt_frame_done` moves to PEND.
  - PEND: on the falling edge of `i_vsync` (registered previous value 1, current 0), move to SWAP. Further `flt_frame_done` pulses are ignored.
  - SWAP: lasts exactly one cycle. No grants are issued. `o_front_bank` toggles at the end of the cycle. `flt_swap_ack` = 1. Next state is RUN.
  - `flt_frame_done` and a vsync falling edge in the same cycle while in RUN: go to PEND only. The swap waits for the next frame.
- Returns are routed by a 2-stage source tag: `dsp_rdata`/`flt_rdata` = `mem_rdata`, qualified by the matching rvalid. Filter writes produce no rvalid.
- In-flight reads issued before a swap complete with their original bank address; the swap does not disturb them.

## Timing
- Cycle N: request and grant high. N+1: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` are registered outputs. N+2: rvalid high with data. Read latency is 2 from grant.
- Back-to-back grants give one RAM access per cycle at full throughput.
- Worst-case filter wait in the active window is MAX_DSP_BURST+1 cycles, plus 1 if a SWAP cycle intervenes.
- Reset values:
  - `dsp_gnt`, `flt_gnt` forced 0 while `rst_n` = 0.
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - Both rvalids = 0, `flt_swap_ack` = 0, `o_front_bank` = 0.
  - FSM = RUN, `dsp_run` = 0, vsync history register = 1.
- Reset mid-operation: pending returns are dropped (no rvalid after reset) and a pending swap is cancelled.

## Structure
- Package `img_arb_pkg` holds:
  - `swap_state_t` enum {RUN, PEND, SWAP}.
  - `src_t` enum {SRC_NONE, SRC_DSP, SRC_FLT} for the return tag pipeline.
  - Default width constants.
- Sub-module `img_arb_swap_fsm` contains the vsync edge detect, swap FSM, `o_front_bank` and `flt_swap_ack`. Grant logic, `dsp_run`, the command register and the tag pipeline stay in the top.

## Test plan
- Display-only reads at addresses 0..3 in the window: grants on 4 consecutive cycles, `mem_addr` = 0x00000..0x00003 on N+1, `dsp_rvalid` with RAM preload data at N+2 each.
- Both requesting continuously with `i_de_window` = 1 and MAX_DSP_BURST = 4: grant pattern D,D,D,D,F repeating; the filter never waits more than 5 cycles.
- Conflict with `i_de_window` = 0: the filter is granted every cycle. A filter write of 0xA5 to 0x0010 drives `mem_addr` = 0x10010 (back bank 1), `mem_we` = 1.
- `flt_frame_done` pulse, then vsync falling edge 100 cycles later:
  - Exactly one no-grant cycle.
  - `o_front_bank` 0→1 and a one-cycle `flt_swap_ack`.
  - Display reads then use bank 1.
  - A display read granted 1 cycle before SWAP returns bank-0 data.
- `flt_frame_done` coincident with a vsync falling edge: no swap on that edge; swap on the next edge.
- Assert `rst_n` low one cycle after a display grant: no rvalid appears, all outputs reach reset values asynchronously, and a pending swap is lost.
